// File: rtl/ofdm_tx_symbol_buffer_if.sv
// ----------------------------------------------------------------------------
// ofdm_tx_symbol_buffer_if
//
// Avalon-ST streaming bundle used on both sides of the OFDM TX symbol buffer.
// One instance carries one direction of traffic.
//
//   data          : complex sample, I/Q packed, DATA_W bits
//   valid         : beat present on data
//   ready         : receiver can take the beat this cycle (ready latency 0)
//   startofpacket : first sample of an OFDM symbol
//   endofpacket   : last sample of an OFDM symbol
//   error         : nonzero on any beat marks the whole symbol bad
//
// Modports:
//   master : drives data/valid/sop/eop/error, receives ready
//   slave  : receives data/valid/sop/eop/error, drives ready
// ----------------------------------------------------------------------------
interface ofdm_tx_symbol_buffer_if #(
  parameter int DATA_W = 34
);
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              ready;
  logic              startofpacket;
  logic              endofpacket;
  logic [1:0]        error;

  modport master (
    output data,
    output valid,
    output startofpacket,
    output endofpacket,
    output error,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    input  startofpacket,
    input  endofpacket,
    input  error,
    output ready
  );
endinterface

// File: rtl/ofdm_tx_symbol_buffer.sv
// ----------------------------------------------------------------------------
// ofdm_tx_symbol_buffer
//
// Store-and-forward ping-pong buffer placed after the OFDM cyclic-prefix
// adder. Complete CP-extended symbols of exactly SYM_LEN samples are captured
// into one of two memory slots; malformed (short, long, restarted, length-1)
// or errored symbols are discarded and counted. Captured symbols are replayed
// as gap-free packets toward the DAC side, never as a partial symbol.
//
// Ports:
//   clk_clk       : single clock, rising edge
//   reset_reset_n : synchronous active-low reset
//   asi_in0       : Avalon-ST sink (slave modport) from the CP adder
//   aso_out0      : Avalon-ST source (master modport) toward the DAC interface;
//                   its error field is always driven 0
//   drop_count    : number of discarded symbols, saturating
//   underrun      : one-cycle pulse when a symbol's last sample leaves and no
//                   further symbol is waiting
// ----------------------------------------------------------------------------
module ofdm_tx_symbol_buffer #(
  parameter int DATA_W  = 34,
  parameter int SYM_LEN = 80,
  parameter int CNT_W   = 16
) (
  input  logic                    clk_clk,
  input  logic                    reset_reset_n,
  ofdm_tx_symbol_buffer_if.slave  asi_in0,
  ofdm_tx_symbol_buffer_if.master aso_out0,
  output logic [CNT_W-1:0]        drop_count,
  output logic                    underrun
);

  localparam int IW = (SYM_LEN > 1) ? $clog2(SYM_LEN) : 1;
  localparam int AW = $clog2(2 * SYM_LEN);
  localparam logic [IW-1:0] LAST_IDX   = IW'(SYM_LEN - 1);
  localparam logic [AW-1:0] SLOT1_BASE = AW'(SYM_LEN);

  typedef enum logic [1:0] {W_IDLE, W_FILL, W_DISCARD} wr_state_t;
  typedef enum logic       {R_IDLE, R_STREAM}          rd_state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [AW-1:0] mem_addr(input logic slot, input logic [IW-1:0] idx);
    return (slot ? SLOT1_BASE : '0) + AW'(idx);
  endfunction

  // Two-slot sample memory; slot s lives at s*SYM_LEN .. s*SYM_LEN+SYM_LEN-1
  logic [DATA_W-1:0] mem [0:2*SYM_LEN-1];

  // A slot is full from commit until its last sample is accepted downstream.
  logic [1:0] full_q;

  // ---------------------------------------------------------------------------
  // Write side: parse incoming symbols into the write slot
  // ---------------------------------------------------------------------------
  wr_state_t         wr_state_q, wr_state_d;
  logic              wr_slot_q;
  logic [IW-1:0]     wr_idx_q, wr_idx_d;
  logic              bad_q, bad_d;
  logic              wr_en;
  logic [IW-1:0]     wr_ofs;
  logic              commit;
  logic              drop;
  logic              in_acc;
  logic              in_err;

  assign asi_in0.ready = !full_q[wr_slot_q];
  assign in_acc        = asi_in0.valid && asi_in0.ready;
  assign in_err        = |asi_in0.error;

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      wr_state_q <= W_IDLE;
      wr_slot_q  <= 1'b0;
      wr_idx_q   <= '0;
      bad_q      <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      wr_idx_q   <= wr_idx_d;
      bad_q      <= bad_d;
      if (commit) wr_slot_q <= ~wr_slot_q;
    end
  end

  always_comb begin
    wr_state_d = wr_state_q;
    if (in_acc) begin
      case (wr_state_q)
        W_IDLE: begin
          if (asi_in0.startofpacket && !asi_in0.endofpacket) wr_state_d = W_FILL;
        end
        W_FILL: begin
          if (asi_in0.startofpacket) begin
            wr_state_d = asi_in0.endofpacket ? W_IDLE : W_FILL;
          end else if (asi_in0.endofpacket) begin
            wr_state_d = W_IDLE;
          end else if (wr_idx_q == LAST_IDX) begin
            // Slot is exhausted without an eop: the symbol is too long.
            wr_state_d = W_DISCARD;
          end
        end
        W_DISCARD: begin
          if (asi_in0.endofpacket) wr_state_d = W_IDLE;
        end
        default: wr_state_d = W_IDLE;
      endcase
    end
  end

  always_comb begin
    wr_en    = 1'b0;
    wr_ofs   = '0;
    wr_idx_d = wr_idx_q;
    bad_d    = bad_q;
    commit   = 1'b0;
    drop     = 1'b0;
    if (in_acc) begin
      case (wr_state_q)
        W_IDLE: begin
          // Beats outside a symbol are ignored; a lone sop+eop beat is a
          // length-1 symbol and is dropped.
          if (asi_in0.startofpacket) begin
            if (asi_in0.endofpacket) begin
              drop = 1'b1;
            end else begin
              wr_en    = 1'b1;
              wr_ofs   = '0;
              wr_idx_d = IW'(1);
              bad_d    = in_err;
            end
          end
        end
        W_FILL: begin
          if (asi_in0.startofpacket) begin
            // Restart: the aborted symbol counts one drop and this beat becomes
            // sample 0. A restart beat that also carries eop just ends the
            // aborted symbol (still one drop).
            drop = 1'b1;
            if (!asi_in0.endofpacket) begin
              wr_en    = 1'b1;
              wr_ofs   = '0;
              wr_idx_d = IW'(1);
              bad_d    = in_err;
            end
          end else begin
            wr_en  = 1'b1;
            wr_ofs = wr_idx_q;
            if (asi_in0.endofpacket) begin
              if (wr_idx_q == LAST_IDX && !bad_q && !in_err) commit = 1'b1;
              else                                           drop   = 1'b1;
            end else begin
              wr_idx_d = wr_idx_q + IW'(1);
              bad_d    = bad_q | in_err;
            end
          end
        end
        W_DISCARD: begin
          if (asi_in0.endofpacket) drop = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_clk) begin
    if (wr_en) mem[mem_addr(wr_slot_q, wr_ofs)] <= asi_in0.data;
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) drop_count <= '0;
    else if (drop)      drop_count <= sat_inc(drop_count);
  end

  // ---------------------------------------------------------------------------
  // Read side: replay full slots, output register is the memory read stage
  // ---------------------------------------------------------------------------
  rd_state_t         rd_state_q, rd_state_d;
  logic              rd_slot_q;
  logic              rd_other;
  logic [IW-1:0]     rd_idx_q, rd_idx_d;
  logic              rd_load;
  logic              rd_load_slot;
  logic [IW-1:0]     rd_load_idx;
  logic              rd_clear;
  logic              release_slot;
  logic              underrun_d;
  logic              out_acc;

  logic [DATA_W-1:0] data_p1;
  logic              sop_p1;
  logic              eop_p1;
  logic              vld_p1;

  assign rd_other = ~rd_slot_q;
  assign out_acc  = vld_p1 && aso_out0.ready;

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      rd_state_q <= R_IDLE;
      rd_slot_q  <= 1'b0;
      rd_idx_q   <= '0;
      underrun   <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      rd_idx_q   <= rd_idx_d;
      underrun   <= underrun_d;
      if (release_slot) rd_slot_q <= ~rd_slot_q;
    end
  end

  always_comb begin
    rd_state_d = rd_state_q;
    case (rd_state_q)
      R_IDLE:   if (full_q[rd_slot_q]) rd_state_d = R_STREAM;
      R_STREAM: if (out_acc && eop_p1 && !full_q[rd_other]) rd_state_d = R_IDLE;
      default:  rd_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    rd_load      = 1'b0;
    rd_load_slot = rd_slot_q;
    rd_load_idx  = '0;
    rd_idx_d     = rd_idx_q;
    rd_clear     = 1'b0;
    release_slot = 1'b0;
    underrun_d   = 1'b0;
    case (rd_state_q)
      R_IDLE: begin
        if (full_q[rd_slot_q]) begin
          rd_load      = 1'b1;
          rd_load_slot = rd_slot_q;
          rd_load_idx  = '0;
          rd_idx_d     = '0;
        end
      end
      R_STREAM: begin
        if (out_acc) begin
          if (eop_p1) begin
            release_slot = 1'b1;
            // The other slot being already full lets its sop follow the eop
            // with no bubble; otherwise the stream runs dry.
            if (full_q[rd_other]) begin
              rd_load      = 1'b1;
              rd_load_slot = rd_other;
              rd_load_idx  = '0;
              rd_idx_d     = '0;
            end else begin
              rd_clear   = 1'b1;
              underrun_d = 1'b1;
            end
          end else begin
            rd_load      = 1'b1;
            rd_load_slot = rd_slot_q;
            rd_load_idx  = rd_idx_q + IW'(1);
            rd_idx_d     = rd_idx_q + IW'(1);
          end
        end
      end
      default: ;
    endcase
  end

  // ---- stage p1: memory read into the output register ----
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      data_p1 <= '0;
      sop_p1  <= 1'b0;
      eop_p1  <= 1'b0;
      vld_p1  <= 1'b0;
    end else if (rd_load) begin
      data_p1 <= mem[mem_addr(rd_load_slot, rd_load_idx)];
      sop_p1  <= (rd_load_idx == '0);
      eop_p1  <= (rd_load_idx == LAST_IDX);
      vld_p1  <= 1'b1;
    end else if (rd_clear) begin
      data_p1 <= '0;
      sop_p1  <= 1'b0;
      eop_p1  <= 1'b0;
      vld_p1  <= 1'b0;
    end
  end

  assign aso_out0.data          = data_p1;
  assign aso_out0.startofpacket = sop_p1;
  assign aso_out0.endofpacket   = eop_p1;
  assign aso_out0.valid         = vld_p1;
  assign aso_out0.error         = 2'b00;

  // ---------------------------------------------------------------------------
  // Slot occupancy: commit and release may coincide; they never hit the same
  // slot because the write slot is never full and the read slot always is.
  // ---------------------------------------------------------------------------
  logic [1:0] full_set;
  logic [1:0] full_clr;

  always_comb begin
    full_set = 2'b00;
    full_clr = 2'b00;
    if (commit)       full_set[wr_slot_q] = 1'b1;
    if (release_slot) full_clr[rd_slot_q] = 1'b1;
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) full_q <= 2'b00;
    else                full_q <= (full_q | full_set) & ~full_clr;
  end

endmodule

// File: tb/tb_ofdm_tx_symbol_buffer.sv
module tb_ofdm_tx_symbol_buffer;
  localparam int DATA_W  = 34;
  localparam int SYM_LEN = 80;
  localparam int CNT_W   = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ofdm_tx_symbol_buffer_if #(.DATA_W(DATA_W)) in_if ();
  ofdm_tx_symbol_buffer_if #(.DATA_W(DATA_W)) out_if ();
  logic [CNT_W-1:0] drop_count;
  logic             underrun;

  ofdm_tx_symbol_buffer #(.DATA_W(DATA_W), .SYM_LEN(SYM_LEN), .CNT_W(CNT_W)) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .asi_in0       (in_if),
    .aso_out0      (out_if),
    .drop_count    (drop_count),
    .underrun      (underrun)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;
  int rdy_mode = 1;  // 0: ready low, 1: ready high, 2: random

  // Behavioural model: symbol parser on queues plus committed-symbol count
  int                occ = 0;
  int                drop_m = 0;
  logic [DATA_W-1:0] cur[$];
  bit                in_sym = 1'b0;
  bit                cur_bad = 1'b0;
  logic [DATA_W-1:0] exp_q[$];
  int                opos = 0;
  bit                und_next = 1'b0;
  bit                stall_prev = 1'b0;
  logic [DATA_W-1:0] prev_data;
  logic              prev_sop, prev_eop;

  // Per-test statistics
  int                out_cnt, und_cnt, commit_cyc, first_valid_cyc, first_acc_cyc, last_acc_cyc;
  logic [DATA_W-1:0] first_out_data, last_out_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_stats();
    out_cnt = 0; und_cnt = 0;
    commit_cyc = -1; first_valid_cyc = -1; first_acc_cyc = -1; last_acc_cyc = -1;
    first_out_data = '0; last_out_data = '0;
  endtask

  always @(negedge clk) out_if.ready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);

  always @(posedge clk) begin : model
    int occ0;
    bit eop_m;
    logic [DATA_W-1:0] e;
    cyc++;
    if (!rst_n) begin
      occ = 0; drop_m = 0; cur.delete(); in_sym = 0; cur_bad = 0;
      exp_q.delete(); opos = 0; und_next = 0; stall_prev = 0;
    end else begin
      occ0 = occ;
      und_next = 0;
      stall_prev = out_if.valid && !out_if.ready;
      prev_data = out_if.data; prev_sop = out_if.startofpacket; prev_eop = out_if.endofpacket;
      if (chk_en && out_if.valid && out_if.ready) begin
        eop_m = (opos == SYM_LEN - 1);
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL out_unexpected: got data %0d expected no beat", out_if.data);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", out_if.data, e);
          chk("out_sop", out_if.startofpacket, opos == 0);
          chk("out_eop", out_if.endofpacket, eop_m);
        end
        if (first_acc_cyc < 0) begin first_acc_cyc = cyc; first_out_data = out_if.data; end
        last_acc_cyc = cyc; last_out_data = out_if.data; out_cnt++;
        if (eop_m) begin und_next = (occ0 == 1); occ--; opos = 0; end
        else opos++;
      end
      if (in_if.valid && occ0 < 2) begin
        if (in_if.startofpacket) begin
          if (in_sym) drop_m++;
          cur.delete(); cur.push_back(in_if.data); cur_bad = (in_if.error != 0);
          if (in_if.endofpacket) begin drop_m++; in_sym = 0; end
          else in_sym = 1;
        end else if (in_sym) begin
          cur.push_back(in_if.data);
          cur_bad = cur_bad | (in_if.error != 0);
          if (in_if.endofpacket) begin
            in_sym = 0;
            if (cur.size() == SYM_LEN && !cur_bad) begin
              foreach (cur[i]) exp_q.push_back(cur[i]);
              occ++;
              if (commit_cyc < 0) commit_cyc = cyc;
            end else drop_m++;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      chk("in_ready", in_if.ready, occ < 2);
      chk("drop_count", drop_count, drop_m);
      chk("underrun", underrun, und_next);
      if (underrun) und_cnt++;
      if (out_if.valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (out_if.valid) chk("valid_needs_symbol", occ > 0, 1);
      if (stall_prev) begin
        chk("hold_valid", out_if.valid, 1);
        chk("hold_data", out_if.data, prev_data);
        chk("hold_sop", out_if.startofpacket, prev_sop);
        chk("hold_eop", out_if.endofpacket, prev_eop);
      end
    end
  end

  task automatic send_beat(input logic [DATA_W-1:0] d, input bit sop, input bit eop, input logic [1:0] err);
    bit r;
    int n;
    in_if.data = d; in_if.startofpacket = sop; in_if.endofpacket = eop;
    in_if.error = err; in_if.valid = 1'b1;
    r = 1'b0;
    for (n = 0; n < 1000; n++) begin
      @(negedge clk); r = in_if.ready;
      @(posedge clk); #1;
      if (r) break;
    end
    if (!r) begin
      total++; bad++;
      $display("FAIL send_timeout: beat %0d got no ready required ready within 1000 cycles", d);
    end
    in_if.valid = 1'b0; in_if.startofpacket = 1'b0; in_if.endofpacket = 1'b0; in_if.error = 2'b00;
  endtask

  task automatic send_sym(input int base, input int n, input int err_at, input bit with_eop);
    for (int i = 0; i < n; i++)
      send_beat(DATA_W'(base + i), i == 0, with_eop && (i == n - 1), (i == err_at) ? 2'b01 : 2'b00);
  endtask

  task automatic drain();
    int n;
    for (n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      if (occ == 0 && exp_q.size() == 0 && !out_if.valid) break;
    end
    if (n >= 3000) begin
      total++; bad++;
      $display("FAIL drain_timeout: got %0d pending samples required 0", exp_q.size());
    end
    repeat (2) begin @(posedge clk); #1; end
  endtask

  initial begin
    in_if.valid = 1'b0; in_if.data = '0; in_if.startofpacket = 1'b0;
    in_if.endofpacket = 1'b0; in_if.error = 2'b00;
    clear_stats();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_if.ready, 1);
    chk("rst_out_valid", out_if.valid, 0);
    chk("rst_out_sop", out_if.startofpacket, 0);
    chk("rst_out_data", out_if.data, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_underrun", underrun, 0);
    @(posedge clk); #1;

    // Two good symbols back to back, ready held high
    clear_stats();
    send_sym(0, 80, -1, 1);
    send_sym(100, 80, -1, 1);
    drain();
    chk("t1_latency", first_valid_cyc - commit_cyc, 1);
    chk("t1_gapfree_span", last_acc_cyc - first_acc_cyc, 159);
    chk("t1_count", out_cnt, 160);
    chk("t1_first", first_out_data, 0);
    chk("t1_last", last_out_data, 179);
    chk("t1_underruns", und_cnt, 1);
    chk("t1_drop", drop_count, 0);

    // Errored symbol then good symbol
    clear_stats();
    send_sym(200, 80, 40, 1);
    send_sym(300, 80, -1, 1);
    drain();
    chk("t2_drop", drop_count, 1);
    chk("t2_count", out_cnt, 80);
    chk("t2_first", first_out_data, 300);
    chk("t2_last", last_out_data, 379);

    // Short, long and restarted symbols
    clear_stats();
    send_sym(400, 51, -1, 1);
    send_sym(500, 91, -1, 1);
    send_sym(600, 30, -1, 0);
    send_sym(700, 80, -1, 1);
    drain();
    chk("t3_drop", drop_count, 4);
    chk("t3_count", out_cnt, 80);
    chk("t3_first", first_out_data, 700);
    chk("t3_last", last_out_data, 779);

    // Downstream stalled while three symbols are offered
    clear_stats();
    rdy_mode = 0;
    @(negedge clk); @(posedge clk); #1;
    send_sym(1000, 80, -1, 1);
    send_sym(1100, 80, -1, 1);
    fork
      send_sym(1200, 80, -1, 1);
      begin
        repeat (30) @(negedge clk);
        chk("t4_in_ready_low", in_if.ready, 0);
        chk("t4_nothing_out", out_cnt, 0);
        chk("t4_held_valid", out_if.valid, 1);
        chk("t4_held_data", out_if.data, 1000);
        rdy_mode = 1;
      end
    join
    drain();
    chk("t4_count", out_cnt, 240);
    chk("t4_first", first_out_data, 1000);
    chk("t4_last", last_out_data, 1279);
    chk("t4_drop", drop_count, 4);

    // Random downstream ready
    clear_stats();
    rdy_mode = 2;
    send_sym(2000, 80, -1, 1);
    send_sym(2100, 80, -1, 1);
    send_sym(2200, 80, -1, 1);
    drain();
    rdy_mode = 1;
    chk("t5_count", out_cnt, 240);
    chk("t5_last", last_out_data, 2279);

    // Reset in the middle of an output symbol
    clear_stats();
    send_sym(3000, 80, -1, 1);
    begin
      int n;
      for (n = 0; n < 500; n++) begin
        if (out_cnt >= 20) break;
        @(posedge clk); #1;
      end
      if (n >= 500) begin
        total++; bad++;
        $display("FAIL t6_wait: got %0d samples out required 20", out_cnt);
      end
    end
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("t6_valid_after_rst", out_if.valid, 0);
    chk("t6_sop_after_rst", out_if.startofpacket, 0);
    chk("t6_data_after_rst", out_if.data, 0);
    chk("t6_ready_after_rst", in_if.ready, 1);
    chk("t6_drop_after_rst", drop_count, 0);
    @(posedge clk); #1;
    clear_stats();
    send_sym(3100, 80, -1, 1);
    drain();
    chk("t6_count", out_cnt, 80);
    chk("t6_first", first_out_data, 3100);
    chk("t6_last", last_out_data, 3179);
    chk("t6_drop", drop_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
